// File: rtl/alu_exec_unit.sv
// Single-cycle ALU execute stage: control decode, ALU and PC adders,
// with every output captured in one register bank.
module alu_exec_unit #(
  parameter int unsigned PC_INC = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  alu_op,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] pc,
  input  logic [31:0] imm_ext,
  output logic [3:0]  alu_ctrl,
  output logic [31:0] result,
  output logic        zero,
  output logic        overflow,
  output logic [31:0] pc_plus4,
  output logic [31:0] branch_target
);

  localparam logic [3:0] C_AND = 4'b0000;
  localparam logic [3:0] C_OR  = 4'b0001;
  localparam logic [3:0] C_ADD = 4'b0010;
  localparam logic [3:0] C_SUB = 4'b0110;
  localparam logic [3:0] C_SLT = 4'b0111;
  localparam logic [3:0] C_NOR = 4'b1100;
  localparam logic [3:0] C_BAD = 4'b1111;

  localparam logic [31:0] INC = 32'(PC_INC);

  logic [3:0]  ctrl_d;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] res_d;
  logic        ovf_d;
  logic [31:0] pp4_d;
  logic [31:0] bt_d;

  always_comb begin
    ctrl_d = C_BAD;
    case (alu_op)
      2'b00: ctrl_d = C_ADD;
      2'b01: ctrl_d = C_SUB;
      2'b11: ctrl_d = C_OR;
      default: begin
        case (funct)
          6'b100000: ctrl_d = C_ADD;
          6'b100010: ctrl_d = C_SUB;
          6'b100100: ctrl_d = C_AND;
          6'b100101: ctrl_d = C_OR;
          6'b100111: ctrl_d = C_NOR;
          6'b101010: ctrl_d = C_SLT;
          default:   ctrl_d = C_BAD;
        endcase
      end
    endcase
  end

  assign sum  = a + b;
  assign diff = a - b;

  always_comb begin
    res_d = '0;
    ovf_d = 1'b0;
    case (ctrl_d)
      C_AND: res_d = a & b;
      C_OR:  res_d = a | b;
      C_NOR: res_d = ~(a | b);
      C_SLT: res_d = {31'd0, $signed(a) < $signed(b)};
      C_ADD: begin
        res_d = sum;
        ovf_d = (a[31] == b[31]) && (sum[31] != a[31]);
      end
      C_SUB: begin
        res_d = diff;
        ovf_d = (a[31] != b[31]) && (diff[31] != a[31]);
      end
      default: res_d = '0;
    endcase
  end

  // Branch offset is a word count, so shift before adding.
  assign pp4_d = pc + INC;
  assign bt_d  = pp4_d + {imm_ext[29:0], 2'b00};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_ctrl      <= '0;
      result        <= '0;
      zero          <= 1'b0;
      overflow      <= 1'b0;
      pc_plus4      <= '0;
      branch_target <= '0;
    end else begin
      alu_ctrl      <= ctrl_d;
      result        <= res_d;
      zero          <= (res_d == '0);
      overflow      <= ovf_d;
      pc_plus4      <= pp4_d;
      branch_target <= bt_d;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit against an
// arithmetic reference model.
module tb_alu_exec_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  alu_op = '0;
  logic [5:0]  funct = '0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] pc = '0;
  logic [31:0] imm_ext = '0;
  logic [3:0]  alu_ctrl;
  logic [31:0] result;
  logic        zero;
  logic        overflow;
  logic [31:0] pc_plus4;
  logic [31:0] branch_target;

  int n_tests = 0;
  int n_fail  = 0;

  alu_exec_unit #(.PC_INC(4)) dut (
    .clk(clk), .rst(rst),
    .alu_op(alu_op), .funct(funct),
    .a(a), .b(b), .pc(pc), .imm_ext(imm_ext),
    .alu_ctrl(alu_ctrl), .result(result),
    .zero(zero), .overflow(overflow),
    .pc_plus4(pc_plus4), .branch_target(branch_target)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_ctrl(input logic [1:0] op,
                                          input logic [5:0] f);
    if (op == 2'd0) return 4'd2;
    if (op == 2'd1) return 4'd6;
    if (op == 2'd3) return 4'd1;
    case (f)
      6'd32:   return 4'd2;
      6'd34:   return 4'd6;
      6'd36:   return 4'd0;
      6'd37:   return 4'd1;
      6'd39:   return 4'd12;
      6'd42:   return 4'd7;
      default: return 4'd15;
    endcase
  endfunction

  // Signed 64-bit arithmetic: overflow means the true value leaves int range.
  task automatic ref_alu(input logic [3:0] c,
                         input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] r, output logic v);
    longint sx, sy, t;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    r = '0;
    v = 1'b0;
    case (c)
      4'd0:  r = x & y;
      4'd1:  r = x | y;
      4'd12: r = ~(x | y);
      4'd7:  r = (sx < sy) ? 32'd1 : 32'd0;
      4'd2, 4'd6: begin
        t = (c == 4'd2) ? sx + sy : sx - sy;
        r = t[31:0];
        v = (t > 64'sd2147483647) || (t < -64'sd2147483648);
      end
      default: r = '0;
    endcase
  endtask

  task automatic run_op(input string tag,
                        input logic [1:0] op, input logic [5:0] f,
                        input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] p, input logic [31:0] im);
    logic [3:0]  ec;
    logic [31:0] er;
    logic        ev;
    @(negedge clk);
    alu_op = op; funct = f; a = x; b = y; pc = p; imm_ext = im;
    ec = ref_ctrl(op, f);
    ref_alu(ec, x, y, er, ev);
    @(posedge clk);
    #1;
    check({tag, ".ctrl"}, 32'(alu_ctrl), 32'(ec));
    check({tag, ".res"}, result, er);
    check({tag, ".zero"}, 32'(zero), 32'(er == 32'd0));
    check({tag, ".ovf"}, 32'(overflow), 32'(ev));
    check({tag, ".pp4"}, pc_plus4, p + 32'd4);
    check({tag, ".bt"}, branch_target, p + 32'd4 + im * 32'd4);
  endtask

  task automatic check_zero_outs(input string tag);
    check({tag, ".ctrl"}, 32'(alu_ctrl), 32'd0);
    check({tag, ".res"}, result, 32'd0);
    check({tag, ".zero"}, 32'(zero), 32'd0);
    check({tag, ".ovf"}, 32'(overflow), 32'd0);
    check({tag, ".pp4"}, pc_plus4, 32'd0);
    check({tag, ".bt"}, branch_target, 32'd0);
  endtask

  logic [5:0] valid_f [6] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd39, 6'd42};

  initial begin
    logic [1:0]  op;
    logic [5:0]  f;
    logic [31:0] x, y;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_zero_outs("reset");
    @(negedge clk);
    rst = 1'b0;

    run_op("pre", 2'b10, 6'd37, 32'hA5A5_0000, 32'h0000_5A5A,
           32'h100, 32'h3);
    // Mid-cycle reset clears outputs before the next edge.
    #2 rst = 1'b1;
    #1 check_zero_outs("rst_async");
    alu_op = 2'b11; a = 32'hFFFF; b = 32'h1; pc = 32'h80;
    @(posedge clk);
    #1 check_zero_outs("rst_hold");
    @(negedge clk);
    #2 rst = 1'b0;
    alu_op = 2'b00; a = 32'd5; b = 32'd7; pc = 32'd0; imm_ext = 32'd0;
    #1 check_zero_outs("rst_release");
    @(posedge clk);
    #1;
    check("first.res", result, 32'd12);
    check("first.ctrl", 32'(alu_ctrl), 32'b0010);
    check("first.zero", 32'(zero), 32'd0);

    run_op("beq", 2'b01, 6'd0, 32'h1234, 32'h1234, 32'h0, 32'h0);
    check("beq.zero_k", 32'(zero), 32'd1);
    check("beq.ctrl_k", 32'(alu_ctrl), 32'b0110);

    run_op("slt1", 2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'h0, 32'h0);
    check("slt1.k", result, 32'd1);
    run_op("slt0", 2'b10, 6'b101010, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h0);
    check("slt0.k", result, 32'd0);

    run_op("addov", 2'b10, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'h0, 32'h0);
    check("addov.res_k", result, 32'h8000_0000);
    check("addov.ovf_k", 32'(overflow), 32'd1);
    run_op("subov", 2'b10, 6'b100010, 32'h8000_0000, 32'd1, 32'h0, 32'h0);
    check("subov.ovf_k", 32'(overflow), 32'd1);

    run_op("nor", 2'b10, 6'b100111, 32'h0F0F_0F0F, 32'h00FF_00FF,
           32'h0, 32'h0);
    check("nor.k", result, 32'hF000_F000);
    run_op("bad", 2'b10, 6'b000000, 32'h1234, 32'h5678, 32'h0, 32'h0);
    check("bad.ctrl_k", 32'(alu_ctrl), 32'b1111);
    check("bad.zero_k", 32'(zero), 32'd1);

    run_op("pcb", 2'b00, 6'd0, 32'd0, 32'd0, 32'h40, 32'hFFFF_FFFE);
    check("pcb.pp4_k", pc_plus4, 32'h44);
    check("pcb.bt_k", branch_target, 32'h3C);
    run_op("pcw", 2'b00, 6'd0, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'd0);
    check("pcw.pp4_k", pc_plus4, 32'h0);

    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) f = valid_f[$urandom_range(0, 5)];
      else f = 6'($urandom);
      x = $urandom;
      case ($urandom_range(0, 3))
        0: y = x;
        1: y = {x[31], 31'($urandom)};
        default: y = $urandom;
      endcase
      run_op("rnd", op, f, x, y, $urandom, $urandom);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_exec_unit.md
ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

Interface
REQ-001 The block SHALL have one parameter: PC_INC, default 4, the constant added to pc to form pc_plus4.
REQ-002 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-003 The block SHALL have the following ports:
- clk  input  1  rising-edge clock; all outputs are registered on it.
- rst  input  1  asynchronous, active-high reset.
- alu_op  input  2  main-control operation class.
- funct  input  6  instruction bits [5:0].
- a  input  32  operand A (register read data 1).
- b  input  32  operand B (register data or sign-extended immediate).
- pc  input  32  current program counter.
- imm_ext  input  32  sign-extended 16-bit branch offset.
- alu_ctrl  output  4  decoded ALU control code.
- result  output  32  ALU result.
- zero  output  1  1 when the ALU result is all zeros (branch compare flag).
- overflow  output  1  signed overflow of ADD or SUB.
- pc_plus4  output  32  pc + PC_INC.
- branch_target  output  32  pc + PC_INC + (imm_ext << 2).

Function
REQ-004 Decode (alu_op -> alu_ctrl) SHALL be:
- 00 -> 0010 (ADD; load/store address).
- 01 -> 0110 (SUB; beq compare).
- 11 -> 0001 (OR; ori).
- 10 -> decode on funct as in REQ-005.
REQ-005 With alu_op=10, funct SHALL map as:
- 100000 -> 0010 (ADD); 100010 -> 0110 (SUB).
- 100100 -> 0000 (AND); 100101 -> 0001 (OR).
- 100111 -> 1100 (NOR); 101010 -> 0111 (SLT).
- any other funct -> 1111 (invalid).
REQ-006 ALU operations SHALL be:
- 0000: a & b.
- 0001: a | b.
- 0010: a + b, modulo 2^32.
- 0110: a - b, modulo 2^32.
- 0111: 32'd1 if signed(a) < signed(b), else 32'd0.
- 1100: ~(a | b).
- any other code: result 0.
REQ-007 zero SHALL equal 1 exactly when the 32-bit result about to be registered is 0; invalid codes therefore give zero=1.
REQ-008 overflow SHALL be 1 only for ADD or SUB when the operand signs and result sign indicate two's-complement overflow; it SHALL be 0 for all other codes.
REQ-009 pc_plus4 SHALL be pc + PC_INC, modulo 2^32; carry out is discarded.
REQ-010 branch_target SHALL be (pc + PC_INC) + {imm_ext[29:0], 2'b00}, modulo 2^32; a negative imm_ext gives a backward target.
REQ-011 Decode, ALU and both adders SHALL be combinational from the inputs sampled at a rising clk edge.
REQ-012 All outputs (alu_ctrl, result, zero, overflow, pc_plus4, branch_target) SHALL update together on that same edge.
REQ-013 Latency SHALL be exactly one cycle, with a new operation accepted every cycle and no handshake or stall.
REQ-014 The outputs SHALL reflect only the inputs sampled at the last edge; there are no multi-cycle operations or internal state beyond the output registers.

Reset
REQ-015 While rst=1, all outputs SHALL be forced to 0 immediately, independent of clk: alu_ctrl=0000, result=0, zero=0, overflow=0, pc_plus4=0, branch_target=0.
REQ-016 An operation in flight when rst asserts SHALL be discarded.
REQ-017 The first operation after reset SHALL be the one sampled at the first rising clk edge with rst=0.
REQ-018 Asserting or deasserting rst between clock edges SHALL cause no spurious register update.

Verification
REQ-019 Reset check: assert rst mid-cycle -> all outputs read 0 before the next edge; release rst, then drive alu_op=00, a=5, b=7 -> one edge later result=12, alu_ctrl=0010, zero=0.
REQ-020 beq compare: alu_op=01, a=b=0x1234 -> result=0, zero=1, alu_ctrl=0110.
REQ-021 Signed SLT: alu_op=10, funct=101010, a=0xFFFFFFFF, b=1 -> result=1; swapping a and b -> result=0.
REQ-022 Overflow cases:
- alu_op=10, funct=100000, a=0x7FFFFFFF, b=1 -> result=0x80000000, overflow=1.
- funct=100010, a=0x80000000, b=1 -> overflow=1.
REQ-023 Bitwise and invalid codes:
- funct=100111 (NOR), a=0x0F0F0F0F, b=0x00FF00FF -> result=0xF000F000.
- funct=000000 -> alu_ctrl=1111, result=0, zero=1.
REQ-024 PC adders: pc=0x00000040, imm_ext=0xFFFFFFFE -> pc_plus4=0x44, branch_target=0x3C. pc=0xFFFFFFFC -> pc_plus4=0 (wrap).
